// File: rtl/mc_control_if.sv
// Control-unit port bundle: the datapath's status inputs and the sequencing strobes.
// master = control unit, slave = datapath / memory side.
interface mc_control_if;
    logic [6:0] opcode;
    logic       take_jmp;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic       pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       instret;
    logic       halted;
    logic [1:0] err_code;
    logic [2:0] state;

    modport master (
        input  opcode, take_jmp, imem_ready, dmem_ready,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we,
               wb_sel, instret, halted, err_code, state
    );

    modport slave (
        output opcode, take_jmp, imem_ready, dmem_ready,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we,
               wb_sel, instret, halted, err_code, state
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing with
// per-access timeout and illegal-opcode detection into a sticky halt.
module mc_control #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic          clk,
    input  logic          rst,
    mc_control_if.master  bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    state_t            r_state;
    logic [6:0]        r_op_q;
    logic [TO_W-1:0]   r_cnt;
    logic              r_halted;
    logic [1:0]        r_err;

    state_t            w_nxt;
    logic [1:0]        w_err_nxt;
    logic              w_to_hit;
    logic              w_imem_req, w_dmem_req, w_dmem_we, w_ir_we;
    logic              w_pc_we, w_pc_sel, w_rf_we, w_instret;
    logic [1:0]        w_wb_sel;

    assign w_to_hit = (r_cnt == TO_W'(MEM_TIMEOUT - 1));

    // Next-state and strobe decode
    always_comb begin
        w_nxt      = r_state;
        w_err_nxt  = r_err;
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_ir_we    = 1'b0;
        w_pc_we    = 1'b0;
        w_pc_sel   = 1'b0;
        w_rf_we    = 1'b0;
        w_wb_sel   = 2'b00;
        w_instret  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_ready) begin
                    w_ir_we = 1'b1;
                    w_nxt   = S_DECODE;
                end else if (w_to_hit) begin
                    w_nxt     = S_HALT;
                    w_err_nxt = 2'b10;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL,
                    OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: w_nxt = S_EXEC;
                    default: begin
                        w_nxt     = S_HALT;
                        w_err_nxt = 2'b01;
                    end
                endcase
            end
            S_EXEC: begin
                case (r_op_q)
                    OPC_BRANCH: begin
                        w_pc_we   = 1'b1;
                        w_pc_sel  = bus.take_jmp;
                        w_instret = 1'b1;
                        w_nxt     = S_FETCH;
                    end
                    OPC_LOAD, OPC_STORE: w_nxt = S_MEM;
                    default:             w_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (r_op_q == OPC_STORE);
                if (bus.dmem_ready) begin
                    if (r_op_q == OPC_STORE) begin
                        w_pc_we   = 1'b1;
                        w_instret = 1'b1;
                        w_nxt     = S_FETCH;
                    end else begin
                        w_nxt = S_WB;
                    end
                end else if (w_to_hit) begin
                    w_nxt     = S_HALT;
                    w_err_nxt = 2'b11;
                end
            end
            S_WB: begin
                w_rf_we   = 1'b1;
                w_pc_we   = 1'b1;
                w_instret = 1'b1;
                w_nxt     = S_FETCH;
                case (r_op_q)
                    OPC_JAL, OPC_JALR: begin
                        w_pc_sel = 1'b1;
                        w_wb_sel = 2'b10;
                    end
                    OPC_LOAD:  w_wb_sel = 2'b01;
                    OPC_AUIPC: w_wb_sel = 2'b11;
                    default:   w_wb_sel = 2'b00;
                endcase
            end
            S_HALT: w_nxt = S_HALT;
            default: begin
                w_nxt     = S_HALT;
                w_err_nxt = 2'b01;
            end
        endcase
    end

    // State, latched opcode, access timer and halt status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_op_q   <= 7'd0;
            r_cnt    <= '0;
            r_halted <= 1'b0;
            r_err    <= 2'b00;
        end else begin
            r_state  <= w_nxt;
            if (r_state == S_DECODE) r_op_q <= bus.opcode;
            // Staying in FETCH/MEM means a wait cycle; any transition restarts the timer
            if ((r_state == S_FETCH || r_state == S_MEM) && w_nxt == r_state)
                r_cnt <= r_cnt + TO_W'(1);
            else
                r_cnt <= '0;
            r_halted <= (w_nxt == S_HALT);
            r_err    <= w_err_nxt;
        end
    end

    // Reset kills any strobe from an access in flight
    assign bus.imem_req = w_imem_req & ~rst;
    assign bus.dmem_req = w_dmem_req & ~rst;
    assign bus.dmem_we  = w_dmem_we  & ~rst;
    assign bus.ir_we    = w_ir_we    & ~rst;
    assign bus.pc_we    = w_pc_we    & ~rst;
    assign bus.pc_sel   = w_pc_sel   & ~rst;
    assign bus.rf_we    = w_rf_we    & ~rst;
    assign bus.wb_sel   = w_wb_sel   & {2{~rst}};
    assign bus.instret  = w_instret  & ~rst;
    assign bus.halted   = r_halted;
    assign bus.err_code = r_err;
    assign bus.state    = r_state;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_mc_control;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_control_if bus ();

    mc_control #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic [15:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Strobe field: {imem_req,dmem_req,dmem_we,ir_we,pc_we,pc_sel,rf_we,wb_sel[1:0],instret}
    localparam logic [9:0] NONE   = 10'b0000000000;
    localparam logic [9:0] F_ACK  = 10'b1001000000;
    localparam logic [9:0] F_WAIT = 10'b1000000000;
    localparam logic [9:0] WB_ALU = 10'b0000101001;
    localparam logic [9:0] WB_LD  = 10'b0000101011;
    localparam logic [9:0] WB_JAL = 10'b0000111101;
    localparam logic [9:0] WB_AUI = 10'b0000101111;
    localparam logic [9:0] BR_T   = 10'b0000110001;
    localparam logic [9:0] BR_N   = 10'b0000100001;
    localparam logic [9:0] M_RD   = 10'b0100000000;
    localparam logic [9:0] M_WR   = 10'b0110000000;
    localparam logic [9:0] ST_OK  = 10'b0110100001;

    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] ST   = 7'b0100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] AUI  = 7'b0010111;
    localparam logic [6:0] ILL  = 7'b1110011;

    // One clock of stimulus; optionally queue the outputs expected for this cycle
    task automatic step(input string nm, input logic r, input logic [6:0] op,
                        input logic tj, input logic ir, input logic dr, input logic chk,
                        input logic [2:0] st, input logic h, input logic [1:0] e,
                        input logic [9:0] s);
        exp_t x;
        @(posedge clk);
        #1;
        rst            = r;
        bus.opcode     = op;
        bus.take_jmp   = tj;
        bus.imem_ready = ir;
        bus.dmem_ready = dr;
        if (chk) begin
            x.name = nm;
            x.v    = {st, h, e, s};
            q.push_back(x);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle
    always @(negedge clk) begin
        logic [15:0] act;
        exp_t        x;
        if (q.size() > 0) begin
            x   = q.pop_front();
            act = {bus.state, bus.halted, bus.err_code, bus.imem_req, bus.dmem_req,
                   bus.dmem_we, bus.ir_we, bus.pc_we, bus.pc_sel, bus.rf_we,
                   bus.wb_sel, bus.instret};
            checks++;
            if (act !== x.v) begin
                errors++;
                $display("FAIL %s: got %b expected %b", x.name, act, x.v);
            end
        end
    end

    initial begin
        rst = 1'b1; bus.opcode = 7'd0; bus.take_jmp = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;

        step("rst0",   1, 0,   0, 1, 1, 0, 0, 0, 0, NONE);
        step("rst",    1, 0,   0, 1, 1, 1, 0, 0, 0, NONE);

        // ADD, zero-wait
        step("add_f",  0, ADD, 0, 1, 0, 1, 0, 0, 0, F_ACK);
        step("add_d",  0, ADD, 0, 0, 0, 1, 1, 0, 0, NONE);
        step("add_e",  0, ADD, 0, 0, 0, 1, 2, 0, 0, NONE);
        step("add_wb", 0, ADD, 0, 0, 0, 1, 4, 0, 0, WB_ALU);

        // BRANCH taken then not taken
        step("brt_f",  0, BR,  1, 1, 0, 1, 0, 0, 0, F_ACK);
        step("brt_d",  0, BR,  1, 0, 0, 1, 1, 0, 0, NONE);
        step("brt_e",  0, BR,  1, 0, 0, 1, 2, 0, 0, BR_T);
        step("brn_f",  0, BR,  0, 1, 0, 1, 0, 0, 0, F_ACK);
        step("brn_d",  0, BR,  0, 0, 0, 1, 1, 0, 0, NONE);
        step("brn_e",  0, BR,  0, 0, 0, 1, 2, 0, 0, BR_N);

        // LOAD with 3 data wait states; ready lands on the timeout cycle
        step("ld_f",   0, LD,  0, 1, 0, 1, 0, 0, 0, F_ACK);
        step("ld_d",   0, LD,  0, 0, 1, 1, 1, 0, 0, NONE);
        step("ld_e",   0, LD,  0, 0, 0, 1, 2, 0, 0, NONE);
        for (int i = 0; i < 3; i++)
            step("ld_mw", 0, LD, 0, 1, 0, 1, 3, 0, 0, M_RD);
        step("ld_m",   0, LD,  0, 0, 1, 1, 3, 0, 0, M_RD);
        step("ld_wb",  0, LD,  0, 0, 0, 1, 4, 0, 0, WB_LD);

        // Fetch ready in exactly the last allowed cycle, then JAL
        for (int i = 0; i < 3; i++)
            step("fb_w", 0, JAL, 0, 0, 0, 1, 0, 0, 0, F_WAIT);
        step("fb_ok",  0, JAL, 0, 1, 0, 1, 0, 0, 0, F_ACK);
        step("jal_d",  0, JAL, 0, 0, 0, 1, 1, 0, 0, NONE);
        step("jal_e",  0, JAL, 0, 0, 0, 1, 2, 0, 0, NONE);
        step("jal_wb", 0, JAL, 0, 0, 0, 1, 4, 0, 0, WB_JAL);

        // AUIPC write-back source
        step("aui_f",  0, AUI, 0, 1, 0, 1, 0, 0, 0, F_ACK);
        step("aui_d",  0, AUI, 0, 0, 0, 1, 1, 0, 0, NONE);
        step("aui_e",  0, AUI, 0, 0, 0, 1, 2, 0, 0, NONE);
        step("aui_wb", 0, AUI, 0, 0, 0, 1, 4, 0, 0, WB_AUI);

        // STORE zero-wait
        step("st_f",   0, ST,  0, 1, 0, 1, 0, 0, 0, F_ACK);
        step("st_d",   0, ST,  0, 0, 0, 1, 1, 0, 0, NONE);
        step("st_e",   0, ST,  0, 0, 0, 1, 2, 0, 0, NONE);
        step("st_m",   0, ST,  0, 0, 1, 1, 3, 0, 0, ST_OK);

        // STORE aborted by reset during MEM
        step("sr_f",   0, ST,  0, 1, 0, 1, 0, 0, 0, F_ACK);
        step("sr_d",   0, ST,  0, 0, 0, 1, 1, 0, 0, NONE);
        step("sr_e",   0, ST,  0, 0, 0, 1, 2, 0, 0, NONE);
        step("sr_mw",  0, ST,  0, 0, 0, 1, 3, 0, 0, M_WR);
        step("sr_rst", 1, ST,  0, 0, 1, 1, 3, 0, 0, NONE);

        // Fetch timeout: 4 request cycles without ready, then sticky halt
        for (int i = 0; i < 4; i++)
            step("fto_w", 0, ADD, 0, 0, 0, 1, 0, 0, 0, F_WAIT);
        for (int i = 0; i < 3; i++)
            step("fto_h", 0, ADD, 0, 1, 1, 1, 5, 1, 2'b10, NONE);

        // Illegal opcode
        step("rst2",   1, ILL, 0, 0, 0, 0, 0, 0, 0, NONE);
        step("ill_f",  0, ILL, 0, 1, 0, 1, 0, 0, 0, F_ACK);
        step("ill_d",  0, ILL, 0, 0, 0, 1, 1, 0, 0, NONE);
        for (int i = 0; i < 2; i++)
            step("ill_h", 0, ILL, 0, 1, 1, 1, 5, 1, 2'b01, NONE);

        // Data timeout on a LOAD
        step("rst3",   1, LD,  0, 0, 0, 0, 0, 0, 0, NONE);
        step("dto_f",  0, LD,  0, 1, 0, 1, 0, 0, 0, F_ACK);
        step("dto_d",  0, LD,  0, 0, 0, 1, 1, 0, 0, NONE);
        step("dto_e",  0, LD,  0, 0, 0, 1, 2, 0, 0, NONE);
        for (int i = 0; i < 4; i++)
            step("dto_w", 0, LD, 0, 0, 0, 1, 3, 0, 0, M_RD);
        step("dto_h",  0, LD,  0, 0, 1, 1, 5, 1, 2'b11, NONE);

        step("end",    1, 0,   0, 0, 0, 0, 0, 0, 0, NONE);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the RV32I core. It sequences the shared ALU, register file, PC register and the instruction and data memory ports through fetch, decode, execute, memory and write-back states, one instruction at a time. The current instruction opcode and the ALU `take_jmp` flag drive state transitions. A per-access timeout and an illegal-opcode check put the core into a sticky halt state.

## Interface

Parameters:
- `MEM_TIMEOUT`, default 255: maximum number of request cycles allowed before a memory handshake is declared failed. Legal range is 2..2^`TO_W`-1.
- `TO_W`, default 8: width of the timeout counter.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 7: `IR[6:0]`. Valid from DECODE onward.
- `take_jmp` input 1: ALU branch-taken flag. Sampled in EXEC.
- `imem_ready` input 1: instruction memory handshake completion.
- `dmem_ready` input 1: data memory handshake completion.
- `imem_req` output 1: instruction fetch request.
- `dmem_req` output 1: data access request.
- `dmem_we` output 1: data write enable. Qualified by `dmem_req`.
- `ir_we` output 1: instruction register load strobe.
- `pc_we` output 1: PC update strobe.
- `pc_sel` output 1: PC source. 0 = PC+4; 1 = branch/jump target.
- `rf_we` output 1: register file write strobe.
- `wb_sel` output 2: write-back source. 00 = ALU `busC`; 01 = load data; 10 = PC+4; 11 = PC+imm.
- `instret` output 1: one-cycle pulse per retired instruction.
- `halted` output 1: sticky halt flag.
- `err_code` output 2: halt cause. 00 none; 01 illegal opcode; 10 imem timeout; 11 dmem timeout.
- `state` output 3: current state, for debug.

## Operation

State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are unreachable; if entered, go to HALT with `err_code`=01.

- **FETCH**
  - `imem_req`=1.
  - On `imem_ready`=1: `ir_we`=1 in the same cycle, next state DECODE.
- **DECODE**
  - `opcode` is latched into an internal `op_q`.
  - Legal opcodes: `OP_IMM`, `OP`, `LUI`, `AUIPC`, `JAL`, `JALR`, `BRANCH`, `LOAD`, `STORE`. Legal opcode → EXEC.
  - Any other opcode → HALT with `err_code`=01.
- **EXEC** (ALU evaluates)
  - `BRANCH`: `pc_we`=1, `pc_sel`=`take_jmp`, `instret`=1, next state FETCH.
  - `LOAD`, `STORE`: next state MEM.
  - All other legal opcodes: next state WB.
- **MEM**
  - `dmem_req`=1, `dmem_we`=(`op_q`==`STORE`).
  - On `dmem_ready`, STORE: `pc_we`=1, `pc_sel`=0, `instret`=1, next state FETCH.
  - On `dmem_ready`, LOAD: next state WB.
- **WB**
  - `rf_we`=1, `pc_we`=1, `instret`=1, next state FETCH.
  - `pc_sel`=1 for `JAL`/`JALR`, else 0.
  - `wb_sel`: 10 for `JAL`/`JALR`, 01 for `LOAD`, 11 for `AUIPC`, 00 otherwise.
- **HALT**
  - All strobes and requests are 0. `halted`=1.
  - Stays in HALT until `rst`.
- **Output decode**
  - Strobes are combinational from `state`, `op_q`, `take_jmp` and the ready inputs.
  - `halted`, `err_code` and `state` are registered.
  - `wb_sel` and `pc_sel` are 0 outside the states listed above.
- **Timeout**
  - The counter clears on entry to FETCH or MEM.
  - It increments each cycle the request is high and ready is low.
  - If ready is still low in the request's `MEM_TIMEOUT`-th cycle, next state is HALT with `err_code` 10 (FETCH) or 11 (MEM).
  - Ready in exactly that cycle wins: the access completes normally.

## Timing

- **Reset**
  - While `rst`=1, all outputs are 0. `state` register = FETCH, `op_q`=0, counter=0, `halted`=0, `err_code`=00.
  - The first cycle after deassertion is FETCH with `imem_req`=1.
  - `rst` asserted mid-access aborts the access. No strobe is issued in the reset cycle.
- **Latency with zero-wait memory** (ready high in the first request cycle):
  - ALU ops, `LUI`, `AUIPC`, `JAL`, `JALR`: 4 cycles.
  - `BRANCH`: 3 cycles.
  - `STORE`: 4 cycles.
  - `LOAD`: 5 cycles.
  - Each memory wait cycle adds 1.
- **Handshakes**
  - Requests stay high until ready. Ready while the request is low is ignored.
  - `ir_we`, `pc_we`, `rf_we` and `instret` are each exactly one cycle per instruction.
  - `instret` pulses exactly once per instruction and coincides with `pc_we`.
- `imem_req` and `dmem_req` are never high in the same cycle.

## Test plan

1. **ADD, zero-wait memory.** `opcode`=0110011, zero-wait memory → states 0,1,2,4,0. `rf_we`=1 and `wb_sel`=00 in cycle 4, `instret`=1 in cycle 4, 4 cycles total.
2. **BRANCH taken, then not taken.** `opcode`=1100011 with `take_jmp`=1, then a second BRANCH with `take_jmp`=0 → each takes 3 cycles with `pc_we`=1 in EXEC; `pc_sel`=1 for the first, 0 for the second; `rf_we` never asserted.
3. **LOAD with data wait states.** `opcode`=0000011, `dmem_ready` delayed 3 cycles → `dmem_req` high for 4 cycles with `dmem_we`=0, then WB with `wb_sel`=01; 8 cycles total.
4. **Fetch timeout boundary.** `MEM_TIMEOUT`=4 and `imem_ready` never asserted → HALT after 4 request cycles, `err_code`=10, `halted`=1, all strobes 0 until `rst`. Rerun with `imem_ready` asserted in cycle 4 → normal DECODE.
5. **Illegal opcode.** `opcode`=1110011 → HALT from DECODE with `err_code`=01; no `pc_we` or `rf_we`.
6. **Reset mid-access.** `rst` pulsed during MEM of a STORE → no `pc_we` or `instret`; next cycle after release is FETCH with `imem_req`=1.
